aer_to_obi_bridge: RTL
======================

Name: aer_to_obi_bridge

Overview:
- Receives output spike events from the tinyODIN core's AER output port over a 4-phase REQ/ACK handshake.
- Buffers events in a small FIFO.
- Writes each event as one 32-bit word into a memory ring buffer through an OBI master port.
- Forms the outbound path complementing the OBI-to-AER input path beside tinyODIN.

Parameters:
M, 8, AER address width (tinyODIN neuron address bits); legal 1..16
FIFO_DEPTH, 4, event FIFO entries; power of 2, >=2
BUF_WORDS, 256, ring buffer size in 32-bit words; power of 2, >=2

Ports:
CLK  input  1  clock
RST  input  1  reset, asynchronous, active-high
enable_i  input  1  allow acceptance of new AER events
clear_i  input  1  single-cycle pulse: zero wr_ptr_o and evt_cnt_o
base_addr_i  input  32  ring buffer byte base address, word aligned
AEROUT_ADDR  input  M  event address, bundled data, stable while AEROUT_REQ high
AEROUT_REQ  input  1  AER request, asynchronous to CLK
AEROUT_ACK  output  1  AER acknowledge
obi_master_req_o  output  req_t  OBI request: req, addr, we, be, wdata
obi_master_resp_i  input  rsp_t  OBI response: gnt, rvalid, rdata (rdata ignored)
wr_ptr_o  output  $clog2(BUF_WORDS)  next ring word index to write
evt_cnt_o  output  32  committed events, saturating
wrap_o  output  1  one-cycle pulse when wr_ptr_o wraps to 0
busy_o  output  1  FIFO non-empty, or either FSM not idle

Behaviour:
- Reset values: AEROUT_ACK=0, all OBI request fields 0, wr_ptr_o=0, evt_cnt_o=0, wrap_o=0, busy_o=0. FIFO is emptied and both FSMs go to idle.
- AEROUT_REQ passes through a 2-FF synchronizer; its output is req_s.
- AER FSM, state A_IDLE:
  - Accepts when req_s=1, enable_i=1 and the FIFO is not full.
  - On accept: push the event word, register AEROUT_ACK=1, go to A_ACK.
  - FIFO full or enable_i=0: ACK stays low. This is the backpressure mechanism; events are never dropped.
- AER FSM, state A_ACK: when req_s=0, set AEROUT_ACK=0 and return to A_IDLE.
- AER latency: REQ rising at cycle 0 gives req_s=1 at cycle 2, a push at the end of cycle 2, and ACK=1 at cycle 3.
- Event word:
  - Bits [M-1:0] = AEROUT_ADDR, sampled at the push.
  - Upper bits are set per the optional feature.
- OBI FSM, state O_IDLE: if the FIFO is not empty, drive req=1, we=1, be=4'hF, addr=base_addr_i+(wr_ptr_o<<2), wdata=FIFO head; go to O_REQ.
- OBI FSM, state O_REQ:
  - Hold all request fields stable until gnt=1.
  - On gnt: pop the FIFO, drop req to 0 in the next cycle, go to O_RSP.
- OBI FSM, state O_RSP: on rvalid, wr_ptr_o+=1 modulo BUF_WORDS, evt_cnt_o+=1 (saturates at 32'hFFFF_FFFF), return to O_IDLE.
- Wrap: wrap_o pulses in the same cycle the pointer moves from BUF_WORDS-1 to 0.
- Throughput: at most one OBI transaction in flight. With gnt and rvalid each one cycle after assertion, an event is committed every 3 cycles.
- The FIFO supports a push and a pop in the same cycle; occupancy is unchanged when this happens.
- enable_i falling mid-handshake: the A_ACK phase still completes, and the FIFO still drains to memory.
- clear_i:
  - Honoured only in a cycle where busy_o=0; ignored otherwise.
  - When clear_i coincides with rvalid, clear takes priority.
- base_addr_i is sampled each time O_IDLE issues a request. Software changes it only while busy_o=0.
- RST asserted mid-transaction: everything returns to reset state immediately. Any in-flight OBI transaction is abandoned, and any FIFO contents are lost.

Optional Feature:
- Macro AER_OBI_TIMESTAMP_EN.
- Defined:
  - A free-running counter of width 32-M, reset to 0, increments every CLK and wraps.
  - The counter value at push is stored in event word bits [31:M].
- Undefined:
  - Bits [31:M] are zero.
  - No counter is instantiated.

Decomposition:
- Package aer_obi_pkg holds:
  - aer_state_e {A_IDLE, A_ACK}
  - obi_state_e {O_IDLE, O_REQ, O_RSP}
  - constant EVT_W = 32
  - constant BE_ALL = 4'hF
- Sub-module aer_evt_fifo: synchronous FIFO with width EVT_W and depth FIFO_DEPTH, providing full, empty, push and pop.

Test Plan:
- Single event: M=8, base_addr_i=32'h2000_0000, AEROUT_ADDR=8'h5A, REQ pulse with 4-phase handshake, gnt and rvalid 1 cycle late.
  - ACK rises 3 cycles after REQ.
  - One OBI write: addr 32'h2000_0000, wdata 32'h0000_005A (macro off), be 4'hF.
  - wr_ptr_o=1, evt_cnt_o=1.
- Backpressure: gnt held low, 5 events sent with FIFO_DEPTH=4.
  - 4 events are ACKed; the 5th REQ sees ACK stay low.
  - After gnt is released, all 5 words are written in order.
- Wrap: BUF_WORDS=4, 5 events.
  - Writes go to base+0, +4, +8, +C, then base+0.
  - wrap_o pulses once, at the 4th rvalid.
- Stall stability: gnt delayed 7 cycles.
  - req, addr and wdata stay constant over all 7 cycles.
  - Exactly one pop occurs.
- Clear and enable:
  - enable_i=0 with REQ high: ACK stays 0.
  - clear_i while busy_o=1 is ignored.
  - clear_i while idle sets wr_ptr_o=0 and evt_cnt_o=0.
- Timestamp (macro on): events pushed at cycles 10 and 25 have bits [31:8] differing by 15.

Source files
------------

// File: rtl/aer_obi_pkg.sv
// Shared types and constants for the AER-to-OBI event bridge.
// Holds the FSM state encodings and the OBI request/response structs.
package aer_obi_pkg;

  localparam int unsigned EVT_W  = 32;
  localparam logic [3:0]  BE_ALL = 4'hF;

  typedef enum logic {A_IDLE, A_ACK} aer_state_e;

  typedef enum logic [1:0] {O_IDLE, O_REQ, O_RSP} obi_state_e;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } rsp_t;

endpackage

// File: rtl/aer_evt_fifo.sv
// Synchronous event FIFO; push and pop may occur in the same cycle.
// Pointers carry one extra wrap bit to distinguish full from empty.
module aer_evt_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/aer_to_obi_bridge.sv
// AER output events -> FIFO -> one OBI word write each into a ring buffer.
// Define AER_OBI_TIMESTAMP_EN to tag event word bits [31:M] with a free-running cycle count.
module aer_to_obi_bridge
  import aer_obi_pkg::*;
#(
  parameter int unsigned M          = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BUF_WORDS  = 256
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         enable_i,
  input  logic                         clear_i,
  input  logic [31:0]                  base_addr_i,
  input  logic [M-1:0]                 AEROUT_ADDR,
  input  logic                         AEROUT_REQ,
  output logic                         AEROUT_ACK,
  output req_t                         obi_master_req_o,
  input  rsp_t                         obi_master_resp_i,
  output logic [$clog2(BUF_WORDS)-1:0] wr_ptr_o,
  output logic [31:0]                  evt_cnt_o,
  output logic                         wrap_o,
  output logic                         busy_o
);

  localparam int unsigned PW = $clog2(BUF_WORDS);

  logic [1:0]       r_sync;
  logic             w_req_s;
  aer_state_e       r_aer_st;
  logic             r_ack;
  obi_state_e       r_obi_st;
  req_t             r_req;
  logic [PW-1:0]    r_wr_ptr;
  logic [31:0]      r_evt_cnt;
  logic             r_wrap;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_busy;
  logic             w_clear;
  logic [EVT_W-1:0] w_evt;
  logic [EVT_W-1:0] w_head;
  logic             w_unused_rdata;

  assign w_unused_rdata = ^obi_master_resp_i.rdata;

`ifdef AER_OBI_TIMESTAMP_EN
  localparam int unsigned TW = EVT_W - M;
  logic [TW-1:0] r_ts;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_ts <= '0;
    else     r_ts <= r_ts + TW'(1);
  end

  assign w_evt = {r_ts, AEROUT_ADDR};
`else
  assign w_evt = {{(EVT_W-M){1'b0}}, AEROUT_ADDR};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_sync <= '0;
    else     r_sync <= {r_sync[0], AEROUT_REQ};
  end
  assign w_req_s = r_sync[1];

  assign w_push  = (r_aer_st == A_IDLE) && w_req_s && enable_i && !w_full;
  assign w_pop   = (r_obi_st == O_REQ) && obi_master_resp_i.gnt;
  assign w_busy  = !w_empty || (r_aer_st != A_IDLE) || (r_obi_st != O_IDLE);
  assign w_clear = clear_i && !w_busy;

  aer_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_data  (w_evt),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Full FIFO or disabled simply withholds ACK, stalling the sender.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_aer_st <= A_IDLE;
      r_ack    <= 1'b0;
    end else begin
      unique case (r_aer_st)
        A_IDLE: if (w_push) begin
          r_ack    <= 1'b1;
          r_aer_st <= A_ACK;
        end
        A_ACK: if (!w_req_s) begin
          r_ack    <= 1'b0;
          r_aer_st <= A_IDLE;
        end
        default: r_aer_st <= A_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_obi_st  <= O_IDLE;
      r_req     <= '0;
      r_wr_ptr  <= '0;
      r_evt_cnt <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      unique case (r_obi_st)
        O_IDLE: if (!w_empty) begin
          r_req.req   <= 1'b1;
          r_req.we    <= 1'b1;
          r_req.be    <= BE_ALL;
          r_req.addr  <= base_addr_i + {{(32-PW-2){1'b0}}, r_wr_ptr, 2'b00};
          r_req.wdata <= w_head;
          r_obi_st    <= O_REQ;
        end
        O_REQ: if (obi_master_resp_i.gnt) begin
          r_req    <= '0;
          r_obi_st <= O_RSP;
        end
        O_RSP: if (obi_master_resp_i.rvalid) begin
          r_obi_st <= O_IDLE;
          r_wr_ptr <= r_wr_ptr + PW'(1);
          r_wrap   <= (r_wr_ptr == PW'(BUF_WORDS - 1));
          if (r_evt_cnt != 32'hFFFF_FFFF) r_evt_cnt <= r_evt_cnt + 32'd1;
        end
        default: r_obi_st <= O_IDLE;
      endcase
      // Clear wins over a coincident commit.
      if (w_clear) begin
        r_wr_ptr  <= '0;
        r_evt_cnt <= '0;
        r_wrap    <= 1'b0;
      end
    end
  end

  assign AEROUT_ACK       = r_ack;
  assign obi_master_req_o = r_req;
  assign wr_ptr_o         = r_wr_ptr;
  assign evt_cnt_o        = r_evt_cnt;
  assign wrap_o           = r_wrap;
  assign busy_o           = w_busy;

endmodule
